duty_ramp: RTL and testbench
============================

DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clock cycles per ramp step (legal 2..2^20).
REQ-002 SHALL have parameter STEP, default 4: duty LSBs added or removed per ramp step (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid  input  1  new target duty offered.
REQ-006 SHALL have port cmd_duty  input  8  requested target duty (0..255 = 0..255/256).
REQ-007 SHALL have port cmd_ready  output  1  command can be accepted this cycle.
REQ-008 SHALL have port bump  input  1  bumper hit, synchronous to clk.
REQ-009 SHALL have port bump_clr  input  1  release emergency stop.
REQ-010 SHALL have port duty  output  8  registered duty to the downstream PWM generator.
REQ-011 SHALL have port at_target  output  1  duty equals target and not stopped.
REQ-012 SHALL have port stopped  output  1  emergency-stop latched.

Function
REQ-013 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; target <= cmd_duty, tick counter <= 0.
REQ-014 SHALL let an accepted command override any ramp in progress; direction follows the new target from the next edge.
REQ-015 SHALL run a tick counter 0..TICK_DIV-1, wrapping; a step edge is an edge where counter == TICK_DIV-1.
REQ-016 SHALL make the first duty change exactly TICK_DIV edges after the accepting edge, then one change every TICK_DIV edges.
REQ-017 SHALL use registered states HOLD, UP, DOWN, STOP; HOLD->UP when target > duty, HOLD->DOWN when target < duty, UP/DOWN->HOLD when duty == target.
REQ-018 SHALL on a step edge in UP set duty <= min(duty+STEP, target), computed 9-bit; duty never wraps past 255.
REQ-019 SHALL on a step edge in DOWN set duty <= max(duty-STEP, target), computed 9-bit signed; duty never wraps below 0.
REQ-020 SHALL leave duty unchanged on non-step edges and in HOLD.
REQ-021 SHALL drive cmd_ready = 1 in every state except STOP.
REQ-022 SHALL drive at_target = 1 iff state == HOLD; stopped = 1 iff state == STOP.
REQ-023 SHALL accept cmd_duty == current duty with no duty change and at_target staying 1.

Reset
REQ-024 SHALL on rst_n low immediately force duty = 0, target = 0, counter = 0, state = HOLD.
REQ-025 SHALL hold outputs during and after reset at duty = 0, cmd_ready = 1, at_target = 1, stopped = 0.
REQ-026 SHALL abandon any ramp or STOP in progress when reset asserts; no state survives reset.

Configuration
REQ-027 SHALL compile the emergency stop only when macro DUTY_RAMP_ESTOP_EN is defined.
REQ-028 SHALL with DUTY_RAMP_ESTOP_EN: bump high on an edge -> next edge duty = 0, target = 0, state STOP; cmd_valid ignored while STOP.
REQ-029 SHALL with DUTY_RAMP_ESTOP_EN: STOP->HOLD on an edge with bump_clr = 1 and bump = 0; bump wins if both high; duty stays 0.
REQ-030 SHALL without DUTY_RAMP_ESTOP_EN: ignore bump and bump_clr, tie stopped to 0, make STOP unreachable.

Verification
REQ-031 SHALL cover TICK_DIV=4, STEP=4, from reset accept cmd 16 -> duty 4,8,12,16 at edges +4,+8,+12,+16; at_target 1 from +16 only.
REQ-032 SHALL cover STEP=4, ramp 0 -> cmd 255 -> duty ...248,252,255, never 0..3 after 252; at_target 1 at 255.
REQ-033 SHALL cover duty 10, cmd 0, STEP=4 -> duty 6,2,0; no underflow to 254.
REQ-034 SHALL cover duty 8 ramping to 16, cmd 0 accepted -> duty 4 exactly TICK_DIV edges later, then 0.
REQ-035 SHALL cover ESTOP_EN build: bump at duty 100 -> duty 0, cmd_ready 0, stopped 1; cmd 50 ignored; bump_clr -> HOLD, duty 0, cmd_ready 1.
REQ-036 SHALL cover rst_n pulled low mid-ramp, between edges -> duty 0, at_target 1 with no clock edge.

Source files
------------

// File: rtl/duty_ramp_if.sv
// duty_ramp_if: target-duty command handshake for duty_ramp.
// The master offers a new 8-bit target duty with cmd_valid; the slave
// (duty_ramp) signals with cmd_ready whether it can take it this cycle.
interface duty_ramp_if;
  logic       cmd_valid;
  logic [7:0] cmd_duty;
  logic       cmd_ready;

  // Command source side (testbench, host logic).
  modport master (
    output cmd_valid,
    output cmd_duty,
    input  cmd_ready
  );

  // Command sink side (duty_ramp).
  modport slave (
    input  cmd_valid,
    input  cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/duty_ramp.sv
// duty_ramp: slew-rate-limited duty register for a downstream PWM generator.
// A new target duty is accepted over the cmd handshake; the output duty then
// walks toward it by at most STEP LSBs every TICK_DIV clock edges, clamped so
// that it never overshoots the target nor wraps past 0 or 255.
//
// Optional feature, enabled by defining DUTY_RAMP_ESTOP_EN:
//   bumper emergency stop. A bump forces duty/target to 0 and latches STOP,
//   during which commands are refused; bump_clr (with bump low) releases it.
//   Without the macro bump/bump_clr are ignored and stopped is tied low.
module duty_ramp #(
  parameter int TICK_DIV = 50000,  // clock edges per ramp step, 2..2^20
  parameter int STEP     = 4       // duty LSBs per ramp step, 1..255
) (
  input  logic          clk,
  input  logic          rst_n,
  duty_ramp_if.slave    cmd,
  input  logic          bump,
  input  logic          bump_clr,
  output logic [7:0]    duty,
  output logic          at_target,
  output logic          stopped
);

  // Tick counter width; TICK_DIV is at least 2 so $clog2 is at least 1.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]    STEP8     = 8'(STEP);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t          state_reg;
  logic [7:0]      duty_reg;
  logic [7:0]      target_reg;
  logic [CW-1:0]   tick_reg;

  logic            step_edge;
  logic            accept;
  logic [8:0]      up_sum;
  logic [7:0]      up_next;
  logic signed [8:0] dn_diff;
  logic [7:0]      dn_next;

  // Direction implied by a target relative to the present duty.
  function automatic state_t dir_of(input logic [7:0] tgt, input logic [7:0] cur);
    if (tgt > cur)
      return ST_UP;
    else if (tgt < cur)
      return ST_DOWN;
    else
      return ST_HOLD;
  endfunction

  // Step edge: last count of the tick divider.
  assign step_edge = (tick_reg == TICK_LAST);

  // A command is taken only when offered and we are not in STOP.
  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  // Upward step is done 9 bits wide so duty+STEP above 255 clamps to the
  // target instead of wrapping around to a small value.
  always_comb begin
    up_sum  = {1'b0, duty_reg} + {1'b0, STEP8};
    up_next = (up_sum > {1'b0, target_reg}) ? target_reg : up_sum[7:0];
  end

  // Downward step is done 9 bits signed so duty-STEP below 0 is seen as
  // negative and clamps to the target instead of wrapping to ~255.
  always_comb begin
    dn_diff = $signed({1'b0, duty_reg}) - $signed({1'b0, STEP8});
    dn_next = (dn_diff < $signed({1'b0, target_reg})) ? target_reg : dn_diff[7:0];
  end

  // Ramp state machine: tick divider, target latch, duty register and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_HOLD;
      duty_reg   <= 8'd0;
      target_reg <= 8'd0;
      tick_reg   <= '0;
    end else begin
`ifdef DUTY_RAMP_ESTOP_EN
      if (bump) begin
        // Bumper hit wins over everything, including a pending release.
        state_reg  <= ST_STOP;
        duty_reg   <= 8'd0;
        target_reg <= 8'd0;
        tick_reg   <= '0;
      end else if (state_reg == ST_STOP) begin
        // Parked at zero until released; commands are refused meanwhile.
        tick_reg <= '0;
        if (bump_clr)
          state_reg <= ST_HOLD;
      end else
`endif
      if (accept) begin
        // New target replaces any ramp in progress and restarts the divider,
        // so the first change lands exactly TICK_DIV edges from here.
        target_reg <= cmd.cmd_duty;
        tick_reg   <= '0;
        state_reg  <= dir_of(cmd.cmd_duty, duty_reg);
      end else begin
        tick_reg <= step_edge ? '0 : tick_reg + CW'(1);
        case (state_reg)
          ST_HOLD: begin
            state_reg <= dir_of(target_reg, duty_reg);
          end
          ST_UP, ST_DOWN: begin
            if (target_reg == duty_reg) begin
              state_reg <= ST_HOLD;
            end else if (step_edge) begin
              // Arriving on the target returns to HOLD on the same edge so
              // at_target rises together with the final duty value.
              if (target_reg > duty_reg) begin
                duty_reg  <= up_next;
                state_reg <= (up_next == target_reg) ? ST_HOLD : ST_UP;
              end else begin
                duty_reg  <= dn_next;
                state_reg <= (dn_next == target_reg) ? ST_HOLD : ST_DOWN;
              end
            end else begin
              state_reg <= dir_of(target_reg, duty_reg);
            end
          end
          default: begin
            // STOP cannot be entered without the emergency stop compiled in.
            state_reg <= ST_HOLD;
          end
        endcase
      end
    end
  end

  assign duty          = duty_reg;
  assign at_target     = (state_reg == ST_HOLD);
  assign cmd.cmd_ready = (state_reg != ST_STOP);

`ifdef DUTY_RAMP_ESTOP_EN
  assign stopped = (state_reg == ST_STOP);
`else
  assign stopped = 1'b0;
  // Bumper inputs exist on the port list but have no function in this build.
  logic unused_bump_inputs;
  assign unused_bump_inputs = bump | bump_clr;
`endif

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed and randomized checks of duty_ramp against a
// behavioural model that tracks target, duty and edges since the last
// accepted command, moving duty toward target every TICK_DIV edges.
module tb_duty_ramp;

  localparam int TD = 4;
  localparam int ST = 4;
`ifdef DUTY_RAMP_ESTOP_EN
  localparam bit ESTOP = 1'b1;
`else
  localparam bit ESTOP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       bump;
  logic       bump_clr;
  logic [7:0] duty;
  logic       at_target;
  logic       stopped;

  duty_ramp_if ifc ();

  duty_ramp #(.TICK_DIV(TD), .STEP(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (ifc),
    .bump      (bump),
    .bump_clr  (bump_clr),
    .duty      (duty),
    .at_target (at_target),
    .stopped   (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model state.
  int m_duty   = 0;
  int m_target = 0;
  int m_cnt    = 0;
  bit m_stop   = 1'b0;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_duty = 0; m_target = 0; m_cnt = 0; m_stop = 1'b0;
  endtask

  // One rising edge of the spec behaviour, evaluated on the sampled inputs.
  task automatic model_edge();
    if (ESTOP && bump) begin
      m_duty = 0; m_target = 0; m_cnt = 0; m_stop = 1'b1;
    end else if (m_stop) begin
      if (bump_clr) m_stop = 1'b0;
    end else if (ifc.cmd_valid) begin
      m_target = int'(ifc.cmd_duty);
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt % TD == 0 && m_duty != m_target) begin
        if (m_target > m_duty)
          m_duty = (m_duty + ST > m_target) ? m_target : m_duty + ST;
        else
          m_duty = (m_duty - ST < m_target) ? m_target : m_duty - ST;
      end
    end
  endtask

  task automatic check_all();
    chk("duty",      {1'b0, duty},          9'(m_duty));
    chk("at_target", {8'd0, at_target},     {8'd0, (!m_stop && m_duty == m_target)});
    chk("stopped",   {8'd0, stopped},       {8'd0, m_stop});
    chk("cmd_ready", {8'd0, ifc.cmd_ready}, {8'd0, !m_stop});
  endtask

  task automatic tick_chk();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_chk();
  endtask

  task automatic send(input logic [7:0] d);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_duty  = d;
    $display("cyc=%0d cmd %0d offered ready=%0d duty=%0d", cyc, d, ifc.cmd_ready, duty);
    tick_chk();
    ifc.cmd_valid = 1'b0;
  endtask

  // Run until the model reports arrival at target, bounded.
  task automatic settle(input string tag, input int limit);
    int i;
    i = 0;
    while (i < limit && !(m_duty == m_target && !m_stop)) begin
      tick_chk();
      i++;
    end
    chk(tag, {8'd0, at_target}, 9'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bump = 1'b0;
    bump_clr = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_duty = 8'd0;
    #1;
    check_all();
    chk("rst_duty", {1'b0, duty}, 9'd0);
    chk("rst_at_target", {8'd0, at_target}, 9'd1);
    #2 rst_n = 1'b1;
    run(3);

    // From reset: target 16 -> 4,8,12,16 every 4 edges, at_target only at the end.
    send(8'd16);
    for (int k = 1; k <= 16; k++) begin
      tick_chk();
      if (k % 4 == 0) chk("r031_duty", {1'b0, duty}, 9'(k));
      chk("r031_at_target", {8'd0, at_target}, {8'd0, (k == 16)});
    end

    // Ramp to 255 must clamp at the top, not wrap.
    send(8'd255);
    settle("r032_settle", 400);
    chk("r032_top", {1'b0, duty}, 9'd255);
    run(6);

    // Come down to 10, then 0: 6,2,0 without underflow.
    send(8'd10);
    settle("r033_settle10", 400);
    send(8'd0);
    run(4); chk("r033_6", {1'b0, duty}, 9'd6);
    run(4); chk("r033_2", {1'b0, duty}, 9'd2);
    run(4); chk("r033_0", {1'b0, duty}, 9'd0);
    chk("r033_at", {8'd0, at_target}, 9'd1);

    // Override mid-ramp: 8 ramping to 16, command 0 reverses it.
    send(8'd8);
    settle("r034_settle8", 40);
    send(8'd16);
    run(2);
    send(8'd0);
    run(3); chk("r034_hold8", {1'b0, duty}, 9'd8);
    run(1); chk("r034_4", {1'b0, duty}, 9'd4);
    run(4); chk("r034_0", {1'b0, duty}, 9'd0);

    // Command equal to current duty keeps at_target high.
    send(8'd0);
    chk("r023_at", {8'd0, at_target}, 9'd1);
    run(4);
    chk("r023_duty", {1'b0, duty}, 9'd0);

    // Bumper at duty 100.
    send(8'd100);
    settle("r035_settle100", 200);
    bump = 1'b1;
    tick_chk();
    bump = 1'b0;
    if (ESTOP) begin
      chk("r035_duty0", {1'b0, duty}, 9'd0);
      chk("r035_ready0", {8'd0, ifc.cmd_ready}, 9'd0);
      chk("r035_stop1", {8'd0, stopped}, 9'd1);
    end else begin
      chk("r030_duty_kept", {1'b0, duty}, 9'd100);
      chk("r030_stop0", {8'd0, stopped}, 9'd0);
    end
    send(8'd50);
    run(6);
    bump = 1'b1; bump_clr = 1'b1;
    tick_chk();
    bump = 1'b0;
    tick_chk();
    bump_clr = 1'b0;
    chk("r035_ready1", {8'd0, ifc.cmd_ready}, 9'd1);
    run(4);

    // Randomized commands, bumps and releases.
    for (int i = 0; i < 400; i++) begin
      ifc.cmd_valid = ($urandom_range(0, 7) == 0);
      ifc.cmd_duty  = 8'($urandom_range(0, 255));
      bump          = ($urandom_range(0, 59) == 0);
      bump_clr      = ($urandom_range(0, 5) == 0);
      if (ifc.cmd_valid)
        $display("cyc=%0d cmd %0d offered ready=%0d duty=%0d", cyc, ifc.cmd_duty, ifc.cmd_ready, duty);
      tick_chk();
    end
    ifc.cmd_valid = 1'b0; bump = 1'b0; bump_clr = 1'b1;
    tick_chk();
    bump_clr = 1'b0;

    // Reset asserted between edges in the middle of a ramp.
    send(8'd200);
    run(10);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r036_duty", {1'b0, duty}, 9'd0);
    chk("r036_at", {8'd0, at_target}, 9'd1);
    check_all();
    #2 rst_n = 1'b1;
    run(2);
    send(8'd30);
    settle("post_rst_settle", 60);
    chk("post_rst_duty", {1'b0, duty}, 9'd30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
